param_stack: RTL

Parametrised LIFO stack. It is the next-generation replacement for the fixed 3-bit x 32 stack used by the recursive-Fibonacci datapath/controller.
- Adds configurable width and depth.
- Adds full/empty flags, an occupancy count and a single-cycle push+pop (replace-top).
- Adds sticky overflow/underflow error flags and a synchronous flush.
- Sits between the controller FSM (push/pop strobes) and the datapath (return-address/argument storage).

---
 rtl/stack_pkg.sv | 20 ++
 rtl/stack_mem.sv | 30 +++
 rtl/param_stack.sv | 125 ++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the parametrised LIFO stack.
package stack_pkg;

    localparam int unsigned WIDTH_DEF = 3;
    localparam int unsigned DEPTH_DEF = 32;

    // Per-cycle operation decoded from the push/pop strobes
    typedef enum logic [1:0] {
        OP_IDLE    = 2'b00,
        OP_POP     = 2'b01,
        OP_PUSH    = 2'b10,
        OP_REPLACE = 2'b11
    } stack_op_e;

    // Occupancy counter width: enough bits to hold 0..depth inclusive
    function automatic int unsigned clog2_cnt(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, one asynchronous
// read port, no reset (contents are don't-care until written).
module stack_mem #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Synchronous write of one entry
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read of the addressed entry
    always_comb begin
        rdata = mem[raddr];
    end

endmodule

// File: rtl/param_stack.sv
// Parametrised LIFO stack with full/empty flags, occupancy count,
// single-cycle replace-top, sticky error flags and synchronous flush.
module param_stack
    import stack_pkg::*;
#(
    parameter int unsigned      WIDTH    = WIDTH_DEF,
    parameter int unsigned      DEPTH    = DEPTH_DEF,
    parameter logic [WIDTH-1:0] DOUT_RST = '0,
    localparam int unsigned     CW       = clog2_cnt(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] d_out,
    output logic             pop_valid,
    output logic [CW-1:0]    count,
    output logic             is_empty,
    output logic             is_full,
    output logic             overflow,
    output logic             underflow
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    stack_op_e        op;
    logic [CW-1:0]    top_idx;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [AW-1:0]    mem_raddr;
    logic [WIDTH-1:0] mem_rdata;

    // Flags derived directly from occupancy
    always_comb begin
        is_empty = (count == '0);
        is_full  = (count == DEPTH_C);
    end

    // Decode strobes into an operation and drive the memory ports.
    // The read address is forced to 0 when empty so it never leaves the array.
    always_comb begin
        op        = stack_op_e'({push, pop});
        top_idx   = count - 1'b1;
        mem_raddr = is_empty ? '0 : top_idx[AW-1:0];
        mem_we    = 1'b0;
        mem_waddr = count[AW-1:0];
        if (!clear) begin
            unique case (op)
                OP_PUSH: begin
                    mem_we    = !is_full;
                    mem_waddr = count[AW-1:0];
                end
                OP_REPLACE: begin
                    mem_we    = !is_empty;
                    mem_waddr = top_idx[AW-1:0];
                end
                default: begin
                    mem_we    = 1'b0;
                end
            endcase
        end
    end

    stack_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (d_in),
        .raddr (mem_raddr),
        .rdata (mem_rdata)
    );

    // Occupancy, popped data, pop strobe and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            d_out     <= DOUT_RST;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            count     <= '0;
            d_out     <= DOUT_RST;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            pop_valid <= 1'b0;
            unique case (op)
                OP_IDLE: begin
                end
                OP_PUSH: begin
                    if (is_full) begin
                        overflow <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                OP_POP: begin
                    if (is_empty) begin
                        underflow <= 1'b1;
                    end else begin
                        d_out     <= mem_rdata;
                        count     <= count - 1'b1;
                        pop_valid <= 1'b1;
                    end
                end
                OP_REPLACE: begin
                    d_out     <= is_empty ? d_in : mem_rdata;
                    pop_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
